// File: rtl/gshare_predictor_ctrl.sv
// gshare_predictor_ctrl: gshare direction predictor. Owns a PHT of 2-bit
// saturating counters indexed by PC xor global history, keeps the
// speculative GHR (restored on mispredict) and sequences a table flush.
module gshare_predictor_ctrl #(
  parameter int unsigned PHT_ENTRIES = 64,
  parameter int unsigned HIST_BITS   = 6,
  parameter int unsigned PC_LSB      = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pred_valid,
  input  logic [31:0]          pred_pc,
  output logic                 pred_taken,
  output logic [HIST_BITS-1:0] pred_ghr,
  input  logic                 res_valid,
  input  logic [31:0]          res_pc,
  input  logic [HIST_BITS-1:0] res_ghr,
  input  logic                 res_taken,
  input  logic                 res_mispredict,
  input  logic                 flush_req,
  output logic                 busy
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t               state;
  logic [HIST_BITS-1:0] ghr;
  logic [HIST_BITS-1:0] flush_idx;
  logic [CNT_W-1:0]     pht [PHT_ENTRIES];

  logic [HIST_BITS-1:0] pred_idx_c;
  logic [HIST_BITS-1:0] upd_idx_c;
  logic [CNT_W-1:0]     upd_cur_c;
  logic [CNT_W-1:0]     upd_val_c;
  logic                 upd_en_c;
  logic                 clr_en_c;
  logic                 unused_pc_c;

  // PC bits outside the index window are intentionally ignored
  assign unused_pc_c = ^{pred_pc, res_pc};

  // Lookup: zero-latency read of the current table; forced to 0 while flushing
  assign pred_idx_c = pred_pc[PC_LSB +: HIST_BITS] ^ ghr;
  assign pred_taken = (state == IDLE) && pht[pred_idx_c][1];
  assign pred_ghr   = (state == IDLE) ? ghr : '0;

  // Resolution: saturating increment/decrement of the addressed counter
  always_comb begin
    upd_idx_c = res_pc[PC_LSB +: HIST_BITS] ^ res_ghr;
    upd_cur_c = pht[upd_idx_c];
    upd_val_c = upd_cur_c;
    if (res_taken) begin
      if (upd_cur_c != 2'b11) upd_val_c = CNT_W'(upd_cur_c + 2'd1);
    end else begin
      if (upd_cur_c != 2'b00) upd_val_c = CNT_W'(upd_cur_c - 2'd1);
    end
    upd_en_c = (state == IDLE) && res_valid;
    clr_en_c = (state == FLUSH);
  end

  // One counter per entry: flush clear, otherwise resolution write
  for (genvar g = 0; g < PHT_ENTRIES; g++) begin : g_pht
    logic [CNT_W-1:0] cnt;

    // Counter register for entry g
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt <= '0;
      end else if (clr_en_c && (flush_idx == HIST_BITS'(g))) begin
        cnt <= '0;
      end else if (upd_en_c && (upd_idx_c == HIST_BITS'(g))) begin
        cnt <= upd_val_c;
      end
    end

    assign pht[g] = cnt;
  end

  // Control FSM: GHR speculation/restore in IDLE, entry-per-cycle flush sweep
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ghr       <= '0;
      flush_idx <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (res_valid && res_mispredict) begin
            ghr <= {res_ghr[HIST_BITS-2:0], res_taken};
          end else if (pred_valid) begin
            ghr <= {ghr[HIST_BITS-2:0], pred_taken};
          end
          // Flush start overrides any history update in the same cycle
          if (flush_req) begin
            state     <= FLUSH;
            busy      <= 1'b1;
            ghr       <= '0;
            flush_idx <= '0;
          end
        end
        FLUSH: begin
          flush_idx <= HIST_BITS'(flush_idx + 1'b1);
          if (flush_idx == HIST_BITS'(PHT_ENTRIES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gshare_predictor_ctrl.sv
// Bench for gshare_predictor_ctrl: directed vector table, flush and
// reset-mid-flush sequences, then random traffic against a reference model.
module tb_gshare_predictor_ctrl;

  localparam int unsigned N  = 64;
  localparam int unsigned HB = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          pred_valid;
  logic [31:0]   pred_pc;
  logic          pred_taken;
  logic [HB-1:0] pred_ghr;
  logic          res_valid;
  logic [31:0]   res_pc;
  logic [HB-1:0] res_ghr;
  logic          res_taken;
  logic          res_mispredict;
  logic          flush_req;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_pht [N];
  int m_ghr;
  int m_flush_left;

  typedef struct {
    logic        pv;
    logic [31:0] ppc;
    logic        rv;
    logic [31:0] rpc;
    int          rghr;
    logic        rt;
    logic        rm;
    logic        fr;
    int          e_taken;
    int          e_ghr;
    int          e_busy;
  } vec_t;

  vec_t tbl [16];

  gshare_predictor_ctrl #(.PHT_ENTRIES(N), .HIST_BITS(HB), .PC_LSB(2)) dut (
    .clock(clock), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .pred_ghr(pred_ghr),
    .res_valid(res_valid), .res_pc(res_pc), .res_ghr(res_ghr),
    .res_taken(res_taken), .res_mispredict(res_mispredict),
    .flush_req(flush_req), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(logic pv, logic [31:0] ppc, logic rv, logic [31:0] rpc,
                              int rghr, logic rt, logic rm, logic fr,
                              int et, int eg, int eb);
    vec_t v;
    v.pv = pv; v.ppc = ppc; v.rv = rv; v.rpc = rpc; v.rghr = rghr;
    v.rt = rt; v.rm = rm; v.fr = fr;
    v.e_taken = et; v.e_ghr = eg; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_index(logic [31:0] pc, int g);
    return ((int'(pc >> 2)) % N) ^ g;
  endfunction

  function automatic int m_pred_taken(logic [31:0] pc);
    if (m_flush_left > 0) return 0;
    return (m_pht[m_index(pc, m_ghr)] >= 2) ? 1 : 0;
  endfunction

  function automatic int m_pred_ghr();
    return (m_flush_left > 0) ? 0 : m_ghr;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_pht[i] = 0;
    m_ghr = 0;
    m_flush_left = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs
  task automatic m_step();
    int pt;
    int ui;
    if (m_flush_left > 0) begin
      m_pht[N - m_flush_left] = 0;
      m_flush_left--;
    end else begin
      pt = m_pred_taken(pred_pc);
      if (res_valid) begin
        ui = m_index(res_pc, int'(res_ghr));
        if (res_taken) m_pht[ui] = (m_pht[ui] == 3) ? 3 : m_pht[ui] + 1;
        else           m_pht[ui] = (m_pht[ui] == 0) ? 0 : m_pht[ui] - 1;
      end
      if (res_valid && res_mispredict) m_ghr = ((int'(res_ghr) * 2) + int'(res_taken)) % N;
      else if (pred_valid)             m_ghr = ((m_ghr * 2) + pt) % N;
      if (flush_req) begin
        m_ghr = 0;
        m_flush_left = N;
      end
    end
  endtask

  task automatic drive(input vec_t v);
    pred_valid = v.pv; pred_pc = v.ppc;
    res_valid = v.rv; res_pc = v.rpc; res_ghr = HB'(v.rghr);
    res_taken = v.rt; res_mispredict = v.rm; flush_req = v.fr;
  endtask

  // One cycle: drive, check outputs against the model, then clock the edge
  task automatic cyc_model(input vec_t v, input string tag);
    drive(v);
    #2;
    chk({tag, ".pred_taken"}, int'(pred_taken), m_pred_taken(pred_pc));
    chk({tag, ".pred_ghr"},   int'(pred_ghr),   m_pred_ghr());
    chk({tag, ".busy"},       int'(busy),       (m_flush_left > 0) ? 1 : 0);
    @(posedge clock);
    m_step();
    #1;
  endtask

  task automatic idle_in();
    drive(mk(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    int cnt;
    vec_t v;
    idle_in();
    reset = 1'b1;
    m_reset();
    #2;
    chk("reset.busy", int'(busy), 0);
    chk("reset.pred_taken", int'(pred_taken), 0);
    chk("reset.pred_ghr", int'(pred_ghr), 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Directed table: pc 0x100 maps to entry 0 with ghr 0
    tbl[0]  = mk(1, 32'h100, 0, 0,       0, 0, 0, 0, 0, 0,  0); // post-reset lookup
    tbl[1]  = mk(0, 32'h100, 1, 32'h100, 0, 1, 0, 0, 0, 0,  0); // 00->01
    tbl[2]  = mk(0, 32'h100, 1, 32'h100, 0, 1, 0, 0, 0, 0,  0); // 01->10, same-cycle pre-update read
    tbl[3]  = mk(0, 32'h100, 0, 0,       0, 0, 0, 0, 1, 0,  0);
    tbl[4]  = mk(0, 32'h100, 1, 32'h100, 0, 1, 0, 0, 1, 0,  0); // 10->11
    tbl[5]  = mk(0, 32'h100, 1, 32'h100, 0, 1, 0, 0, 1, 0,  0); // stays 11
    tbl[6]  = mk(0, 32'h100, 1, 32'h100, 0, 1, 0, 0, 1, 0,  0); // stays 11
    tbl[7]  = mk(0, 32'h100, 1, 32'h100, 0, 0, 0, 0, 1, 0,  0); // 11->10
    tbl[8]  = mk(0, 32'h100, 0, 0,       0, 0, 0, 0, 1, 0,  0); // hysteresis: still taken
    tbl[9]  = mk(0, 32'h100, 1, 32'h100, 0, 0, 0, 0, 1, 0,  0); // 10->01
    tbl[10] = mk(0, 32'h100, 1, 32'h100, 0, 0, 0, 0, 0, 0,  0); // 01->00
    tbl[11] = mk(0, 32'h100, 0, 0,       0, 0, 0, 0, 0, 0,  0);
    tbl[12] = mk(1, 32'h100, 1, 32'h200, 5, 1, 1, 0, 0, 0,  0); // restore with concurrent predict
    tbl[13] = mk(0, 32'h100, 0, 0,       0, 0, 0, 0, 0, 11, 0); // ghr = 6'b001011
    tbl[14] = mk(0, 32'h100, 1, 32'h100, 0, 1, 0, 1, 0, 11, 0); // resolve + flush same cycle
    tbl[15] = mk(0, 32'h100, 0, 0,       0, 0, 0, 0, 0, 0,  1); // flushing, ghr cleared

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i]);
      #2;
      chk($sformatf("tbl%0d.pred_taken", i), int'(pred_taken), tbl[i].e_taken);
      chk($sformatf("tbl%0d.pred_ghr", i),   int'(pred_ghr),   tbl[i].e_ghr);
      chk($sformatf("tbl%0d.busy", i),       int'(busy),       tbl[i].e_busy);
      @(posedge clock);
      m_step();
      #1;
    end

    // Let the pending flush drain (bounded)
    cnt = 0;
    while (m_flush_left > 0 && cnt < 200) begin
      idle_in();
      cyc_model(mk(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0), "drain");
      cnt++;
    end

    // Flush sequence: train entry 0 to 11, flush with traffic, count busy cycles
    for (int i = 0; i < 4; i++) cyc_model(mk(0, 32'h100, 1, 32'h100, 0, 1, 0, 0, 0, 0, 0), "train");
    cyc_model(mk(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0), "trained");
    cyc_model(mk(0, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0, 0), "flush_pulse");
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      cnt++;
      v = mk(1'($urandom), 32'h100, 1, 32'h100, 0, 1, 1'($urandom), 1'($urandom), 0, 0, 0);
      cyc_model(v, "in_flush");
    end
    chk("flush.busy_cycles", cnt, N);
    cyc_model(mk(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_flush");
    #2;
    chk("post_flush.lookup", int'(pred_taken), 0);

    // Reset mid-flush: asynchronous return to idle
    for (int i = 0; i < N; i++) cyc_model(mk(0, 32'h0, 1, 32'(i << 2), 0, 1, 0, 0, 0, 0, 0), "fill");
    for (int i = 0; i < N; i++) cyc_model(mk(0, 32'h0, 1, 32'(i << 2), 0, 1, 0, 0, 0, 0, 0), "fill2");
    cyc_model(mk(0, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "flush_pulse2");
    for (int i = 0; i < 10; i++) cyc_model(mk(0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "flush_run");
    #1;
    reset = 1'b1;
    m_reset();
    #1;
    chk("mid_flush_reset.busy", int'(busy), 0);
    chk("mid_flush_reset.pred_ghr", int'(pred_ghr), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < N; i++) cyc_model(mk(0, 32'(i << 2), 0, 0, 0, 0, 0, 0, 0, 0, 0), "post_reset_scan");

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      v = mk(1'($urandom), $urandom, ($urandom_range(0, 3) != 0), $urandom,
             int'($urandom_range(0, N - 1)), 1'($urandom), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 299) == 0), 0, 0, 0);
      cyc_model(v, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gshare_predictor_ctrl.md
Name: gshare_predictor_ctrl

Overview:
- Controller and owner of a pattern history table (PHT) of 2-bit saturating branch counters, indexed gshare-style by PC XOR global history.
- Serves one prediction lookup per cycle to fetch and accepts one resolution per cycle from execute/retire.
- Maintains a speculative global history register (GHR) and restores it on mispredict.
- Runs a one-entry-per-cycle flush sequencer that clears the table on request.

Parameters:
PHT_ENTRIES, 64, number of PHT counters; must be a power of 2
HIST_BITS, 6, GHR and index width; equals log2(PHT_ENTRIES)
PC_LSB, 2, lowest PC bit used in the index

Ports:
clock  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
pred_valid  in  1  fetch requests a conditional-branch prediction this cycle
pred_pc  in  32  PC of the branch being predicted
pred_taken  out  1  combinational prediction for pred_pc
pred_ghr  out  HIST_BITS  combinational GHR value used for the lookup; fetch carries it with the branch
res_valid  in  1  resolved conditional branch this cycle
res_pc  in  32  PC of the resolved branch
res_ghr  in  HIST_BITS  pred_ghr captured when this branch was predicted
res_taken  in  1  actual branch outcome
res_mispredict  in  1  predicted direction was wrong
flush_req  in  1  single-cycle request to clear the PHT
busy  out  1  flush sequence in progress

Behaviour:
- Counter encoding: 00 STRONG_NT, 01 NT, 10 T, 11 STRONG_T. Predict taken iff bit 1 is set.
- Counter update, saturating:
  - taken: 00→01→10→11, stays at 11
  - not taken: 11→10→01→00, stays at 00
- Index widths:
  - Predict index = pred_pc[PC_LSB +: HIST_BITS] XOR ghr.
  - Update index = res_pc[PC_LSB +: HIST_BITS] XOR res_ghr.
- Reset (asynchronous): all PHT entries 00, ghr 0, FSM to IDLE, flush index 0.
  - Outputs: busy 0, pred_taken 0, pred_ghr 0.
- Prediction timing:
  - pred_taken and pred_ghr are combinational from the current PHT and ghr, with zero latency.
  - Same-cycle resolve to the same index: the prediction sees the pre-update value. The update is visible the next cycle.
- GHR update, IDLE only, evaluated in priority order:
  1. res_valid & res_mispredict: ghr <= {res_ghr[HIST_BITS-2:0], res_taken}. Any same-cycle pred_valid shift is discarded.
  2. Otherwise pred_valid: ghr <= {ghr[HIST_BITS-2:0], pred_taken}.
  3. Otherwise ghr holds.
- Resolution in IDLE:
  - res_valid updates the counter at the update index at the next edge.
  - res_mispredict without res_valid is ignored.
- FSM states and transitions:
  - IDLE → FLUSH on flush_req. On that edge, ghr is cleared to 0 and the flush index is set to 0.
  - FLUSH: busy=1. Each cycle writes 00 to PHT[flush index], then increments the index.
  - FLUSH → IDLE after the write to entry PHT_ENTRIES-1, so busy is high for exactly PHT_ENTRIES cycles.
- During FLUSH:
  - pred_taken=0 and pred_ghr=0.
  - pred_valid does not shift ghr.
  - res_valid is dropped, including mispredict restores.
  - flush_req is ignored.
- flush_req in the same cycle as res_valid in IDLE: the resolve update is applied and the flush starts. Ghr ends at 0, because the flush clear wins.
- Reset asserted mid-flush: immediately returns to IDLE with busy=0 and all entries 00.
- Flush index wraps naturally at HIST_BITS width. No out-of-range accesses.

Test Plan:
- Post-reset lookup: pred_valid, pred_pc=0x100 → pred_taken=0, pred_ghr=0. Ghr stays 0 next cycle (shifted-in 0).
- Training: no predicts; res_valid pc=0x100 ghr=0 taken=1, two cycles → entry 0 goes 00→01→10. Lookup pc=0x100 with ghr=0 → pred_taken=1.
- Saturation and hysteresis: five taken resolves to entry 0 → 11, stays 11. One not-taken → 10, still predicts taken. Two more not-taken → 00, predicts 0.
- Mispredict restore: res_valid, res_mispredict, res_ghr=6'b000101, res_taken=1, with a concurrent pred_valid → next cycle pred_ghr=6'b001011. The pred shift is ignored.
- Flush: train entry 0 to 11, then pulse flush_req → busy=1 for 64 cycles. pred_taken=0 throughout; a res_valid issued during the flush has no effect. After busy falls, lookup pc=0x100 → 0.
- Reset mid-flush: assert reset on flush cycle 10 → busy=0 without waiting for a clock edge. After reset release, every index predicts 0 and ghr=0.
